fifo_wptr_full_prog: RTL

Write-side pointer and flag generator for the async FIFO family. It is the parametrised successor of the fixed write-pointer/full block.
- Keeps the Gray-coded write pointer for CDC and the binary memory address.
- Adds a runtime-programmable almost-full threshold, a registered fill-level output, a memory write-enable, and a sticky overflow flag with clear.
- Sits in the write clock domain; the read-pointer 2-FF synchroniser and dual-port RAM are external.

---
 rtl/fifo_pkg.sv | 34 +++
 rtl/fifo_gray2bin.sv | 25 ++
 rtl/fifo_wptr_full_prog.sv | 102 ++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg
// Shared definitions for the async FIFO family: depth derivation and the
// Gray/binary conversions used by both the write-side and read-side pointer
// blocks.
//
// Contents:
//   depth_of(addrsize) - number of words addressed by an addrsize-bit index
//   bin2gray(bin)      - reflected binary Gray encode (up to 32 bits)
//   gray2bin(gray)     - reflected binary Gray decode (up to 32 bits)
//
// Narrower pointers are zero-extended into the 32-bit arguments. The
// conversions are exact for any width, because zero upper bits encode and
// decode to zero upper bits.
package fifo_pkg;

  function automatic int depth_of(input int addrsize);
    return 1 << addrsize;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return (bin >> 1) ^ bin;
  endfunction

  // Each binary bit is the XOR of its own Gray bit and every Gray bit above it.
  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin = '0;
    for (int i = 0; i < 32; i++) begin
      bin[i] = ^(gray >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// fifo_gray2bin
// Combinational Gray-to-binary converter of parametrised width. It decodes
// pointers that arrive from the other clock domain in Gray code.
//
// Parameters:
//   WIDTH - pointer width in bits
// Ports:
//   gray  in  WIDTH  Gray-coded value
//   bin   out WIDTH  binary equivalent
module fifo_gray2bin #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // XOR prefix from the MSB downward: bin[i] = ^gray[WIDTH-1:i].
  always_comb begin
    bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/fifo_wptr_full_prog.sv
// fifo_wptr_full_prog
// Write-side pointer and flag generator for the async FIFO. It keeps the
// binary write address and the Gray write pointer that crosses to the read
// domain. It also derives a registered fill level, full flag, almost-full flag
// (with a runtime threshold), and a sticky overflow flag.
//
// Parameters:
//   ADDRSIZE - address width; FIFO depth is 2**ADDRSIZE (ADDRSIZE >= 2)
// Ports:
//   wclk          in   1           write-domain clock
//   wrst          in   1           synchronous active-high reset
//   winc          in   1           write request
//   wq2_rptr      in   ADDRSIZE+1  read pointer (Gray), already synchronised to wclk
//   afull_thresh  in   ADDRSIZE    almost-full threshold, in free slots
//   wovf_clr      in   1           clears the sticky overflow flag
//   wen           out  1           memory write enable (combinational)
//   waddr         out  ADDRSIZE    binary memory write address
//   wptr          out  ADDRSIZE+1  Gray write pointer
//   wfull         out  1           FIFO full (registered)
//   awfull        out  1           almost full (registered)
//   wlevel        out  ADDRSIZE+1  words held as seen by the write side (registered)
//   woverflow     out  1           sticky: a write was attempted while full
module fifo_wptr_full_prog
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE = 4
) (
  input  logic                wclk,
  input  logic                wrst,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  input  logic [ADDRSIZE-1:0] afull_thresh,
  input  logic                wovf_clr,
  output logic                wen,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                awfull,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                woverflow
);

  localparam int DEPTH = depth_of(ADDRSIZE);
  localparam logic [ADDRSIZE:0] DEPTH_V = (ADDRSIZE+1)'(DEPTH);

  logic [ADDRSIZE:0] wbin;
  logic [ADDRSIZE:0] wbinnext;
  logic [ADDRSIZE:0] wgraynext;
  logic [ADDRSIZE:0] rbin;
  logic [ADDRSIZE:0] level_next;
  logic [ADDRSIZE:0] free_next;

  fifo_gray2bin #(
    .WIDTH(ADDRSIZE + 1)
  ) u_rptr_g2b (
    .gray (wq2_rptr),
    .bin  (rbin)
  );

  assign wen   = winc & ~wfull;
  assign waddr = wbin[ADDRSIZE-1:0];

  // The extra pointer MSB tells full from empty. The modular difference
  // therefore always lands in 0..DEPTH, and the wrap needs no special case.
  always_comb begin
    wbinnext   = wbin + {{ADDRSIZE{1'b0}}, wen};
    wgraynext  = (wbinnext >> 1) ^ wbinnext;
    level_next = wbinnext - rbin;
    free_next  = DEPTH_V - level_next;
  end

  // The pointers, level and flags all update on the same edge. The flags
  // therefore describe exactly the pointer value the read side will see.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin   <= '0;
      wptr   <= '0;
      wlevel <= '0;
      wfull  <= 1'b0;
      awfull <= 1'b0;
    end else begin
      wbin   <= wbinnext;
      wptr   <= wgraynext;
      wlevel <= level_next;
      wfull  <= (level_next == DEPTH_V);
      awfull <= (free_next <= {1'b0, afull_thresh});
    end
  end

  // Overflow is checked before the clear, so that a blocked write in the
  // same cycle as a clear pulse is not lost.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      woverflow <= 1'b0;
    end else if (winc && wfull) begin
      woverflow <= 1'b1;
    end else if (wovf_clr) begin
      woverflow <= 1'b0;
    end
  end

endmodule
